// File: rtl/vend_pkg.sv
// Shared definitions for the vending transaction controller:
// state codes, change coin codes and the coin value lookup tables.
package vend_pkg;

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_HOLD   = 2'd1;
    localparam logic [1:0] ST_VEND   = 2'd2;
    localparam logic [1:0] ST_PAYOUT = 2'd3;

    localparam logic [1:0] OUT_DOLLAR  = 2'd0;
    localparam logic [1:0] OUT_QUARTER = 2'd1;
    localparam logic [1:0] OUT_DIME    = 2'd2;
    localparam logic [1:0] OUT_NICKEL  = 2'd3;

    // Values are in cents; users resize to their own credit width.
    typedef logic [15:0] cents_t;

    function automatic logic coinInLegal(input logic [2:0] coinType);
        return coinType <= 3'd5;
    endfunction

    function automatic cents_t coinInValue(input logic [2:0] coinType);
        case (coinType)
            3'd0:    return 16'd5;
            3'd1:    return 16'd10;
            3'd2:    return 16'd25;
            3'd3:    return 16'd50;
            3'd4:    return 16'd100;
            3'd5:    return 16'd500;
            default: return 16'd0;
        endcase
    endfunction

    function automatic cents_t coinOutValue(input logic [1:0] outType);
        case (outType)
            OUT_DOLLAR:  return 16'd100;
            OUT_QUARTER: return 16'd25;
            OUT_DIME:    return 16'd10;
            default:     return 16'd5;
        endcase
    endfunction

    // Largest change coin not exceeding the remainder.
    function automatic logic [1:0] greedyCoin(input cents_t remain);
        if (remain >= 16'd100) begin
            return OUT_DOLLAR;
        end else if (remain >= 16'd25) begin
            return OUT_QUARTER;
        end else if (remain >= 16'd10) begin
            return OUT_DIME;
        end
        return OUT_NICKEL;
    endfunction

endpackage

// File: rtl/change_payout.sv
// Change dispenser: holds the remaining change and offers one greedy coin at a
// time to the mechanism, with one idle cycle between consecutive coins.
module change_payout
    import vend_pkg::*;
#(
    parameter int CREDIT_W = 10
)(
    input  logic                clk,
    input  logic                rst_n,
    input  logic                load_i,
    input  logic [CREDIT_W-1:0] amount_i,
    input  logic                coinOutReady_i,
    output logic                coinOutValid_o,
    output logic [1:0]          coinOutType_o,
    output logic                done_o
);

    logic [CREDIT_W-1:0] remain_q, remain_d;
    logic                active_q, active_d;
    logic                valid_q, valid_d;
    logic [1:0]          type_q, type_d;
    logic                handshake;
    logic [CREDIT_W-1:0] coinValue;

    assign handshake = valid_q & coinOutReady_i;
    assign coinValue = CREDIT_W'(coinOutValue(type_q));
    assign done_o    = handshake && (remain_q == coinValue);

    always_comb begin
        remain_d = remain_q;
        active_d = active_q;
        valid_d  = valid_q;
        type_d   = type_q;
        if (load_i) begin
            remain_d = amount_i;
            active_d = (amount_i != '0);
            valid_d  = 1'b0;
        end else if (handshake) begin
            remain_d = remain_q - coinValue;
            valid_d  = 1'b0;
            active_d = (remain_q != coinValue);
        end else if (active_q && !valid_q) begin
            // Type is captured with valid so it cannot change while stalled.
            valid_d = 1'b1;
            type_d  = greedyCoin(cents_t'(remain_q));
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            remain_q <= '0;
            active_q <= 1'b0;
            valid_q  <= 1'b0;
            type_q   <= 2'd0;
        end else begin
            remain_q <= remain_d;
            active_q <= active_d;
            valid_q  <= valid_d;
            type_q   <= type_d;
        end
    end

    assign coinOutValid_o = valid_q;
    assign coinOutType_o  = type_q;

endmodule

// File: rtl/vend_sequencer.sv
// Vending transaction controller: accumulates credit, validates selections,
// runs the vend handshake with timeout and hands change to change_payout.
module vend_sequencer
    import vend_pkg::*;
#(
    parameter int SLOTS        = 9,
    parameter int CREDIT_W     = 10,
    parameter int MAX_CREDIT   = 500,
    parameter int VEND_TIMEOUT = 1000000
)(
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      coinValid,
    input  logic [2:0]                coinType,
    input  logic                      selValid,
    input  logic [3:0]                selIdx,
    input  logic                      cancel,
    input  logic [SLOTS*CREDIT_W-1:0] priceTable,
    input  logic [SLOTS-1:0]          stockOk,
    output logic                      vendReq,
    output logic [3:0]                vendSlot,
    input  logic                      vendDone,
    output logic                      coinOutValid,
    output logic [1:0]                coinOutType,
    input  logic                      coinOutReady,
    output logic                      coinReject,
    output logic                      selDenied,
    output logic                      fault,
    output logic [CREDIT_W-1:0]       credit,
    output logic                      busy
);

    localparam int TIMER_W = (VEND_TIMEOUT > 2) ? $clog2(VEND_TIMEOUT) : 1;
    localparam logic [TIMER_W-1:0] TIMER_LAST = TIMER_W'(VEND_TIMEOUT - 1);

    logic [1:0]          state_q, state_d;
    logic [CREDIT_W-1:0] credit_q, credit_d;
    logic [CREDIT_W-1:0] remain_q, remain_d;
    logic [3:0]          vendSlot_q, vendSlot_d;
    logic [TIMER_W-1:0]  timer_q, timer_d;
    logic                coinReject_q, coinReject_d;
    logic                selDenied_q, selDenied_d;
    logic                fault_q, fault_d;
    logic                vendReq_q, busy_q;

    logic [CREDIT_W-1:0] coinVal;
    logic [CREDIT_W:0]   coinSum;
    logic                coinOk;
    logic [CREDIT_W-1:0] selPrice;
    logic                selStock, selInRange, selOk;
    logic                payLoad, payDone, payHandshake;
    logic [CREDIT_W-1:0] payAmount, payValue;

    assign coinVal = CREDIT_W'(coinInValue(coinType));
    assign coinSum = {1'b0, credit_q} + {1'b0, coinVal};
    assign coinOk  = coinInLegal(coinType) && (coinSum <= (CREDIT_W+1)'(MAX_CREDIT));

    always_comb begin
        selPrice   = '0;
        selStock   = 1'b0;
        selInRange = 1'b0;
        for (int i = 0; i < SLOTS; i++) begin
            if (selIdx == 4'(i)) begin
                selPrice   = priceTable[i*CREDIT_W +: CREDIT_W];
                selStock   = stockOk[i];
                selInRange = 1'b1;
            end
        end
    end

    assign selOk = selInRange && selStock && (selPrice != '0) &&
                   ((selPrice % CREDIT_W'(5)) == '0) && (credit_q >= selPrice);

    assign payHandshake = coinOutValid & coinOutReady;
    assign payValue     = CREDIT_W'(coinOutValue(coinOutType));

    // Priority in HOLD is cancel > accepted select > coin; a denied select still lets the coin through.
    always_comb begin
        state_d      = state_q;
        credit_d     = credit_q;
        remain_d     = remain_q;
        vendSlot_d   = vendSlot_q;
        timer_d      = timer_q;
        coinReject_d = 1'b0;
        selDenied_d  = 1'b0;
        fault_d      = 1'b0;
        payLoad      = 1'b0;
        payAmount    = credit_q;
        case (state_q)
            ST_IDLE: begin
                selDenied_d = selValid;
                if (coinValid) begin
                    if (coinOk) begin
                        credit_d = coinSum[CREDIT_W-1:0];
                        state_d  = ST_HOLD;
                    end else begin
                        coinReject_d = 1'b1;
                    end
                end
            end
            ST_HOLD: begin
                if (cancel) begin
                    state_d      = ST_PAYOUT;
                    payLoad      = 1'b1;
                    coinReject_d = coinValid;
                end else if (selValid && selOk) begin
                    state_d      = ST_VEND;
                    vendSlot_d   = selIdx;
                    remain_d     = credit_q - selPrice;
                    timer_d      = '0;
                    coinReject_d = coinValid;
                end else begin
                    selDenied_d = selValid;
                    if (coinValid) begin
                        if (coinOk) begin
                            credit_d = coinSum[CREDIT_W-1:0];
                        end else begin
                            coinReject_d = 1'b1;
                        end
                    end
                end
            end
            ST_VEND: begin
                coinReject_d = coinValid;
                if (vendDone) begin
                    if (remain_q == '0) begin
                        state_d  = ST_IDLE;
                        credit_d = '0;
                    end else begin
                        state_d   = ST_PAYOUT;
                        payLoad   = 1'b1;
                        payAmount = remain_q;
                        credit_d  = remain_q;
                    end
                end else if (timer_q == TIMER_LAST) begin
                    // credit_q still holds the pre-selection credit, so the refund is complete.
                    fault_d = 1'b1;
                    state_d = ST_PAYOUT;
                    payLoad = 1'b1;
                end else begin
                    timer_d = timer_q + TIMER_W'(1);
                end
            end
            default: begin
                coinReject_d = coinValid;
                if (payDone) begin
                    state_d  = ST_IDLE;
                    credit_d = '0;
                end else if (payHandshake) begin
                    credit_d = credit_q - payValue;
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            credit_q     <= '0;
            remain_q     <= '0;
            vendSlot_q   <= 4'd0;
            timer_q      <= '0;
            coinReject_q <= 1'b0;
            selDenied_q  <= 1'b0;
            fault_q      <= 1'b0;
            vendReq_q    <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            credit_q     <= credit_d;
            remain_q     <= remain_d;
            vendSlot_q   <= vendSlot_d;
            timer_q      <= timer_d;
            coinReject_q <= coinReject_d;
            selDenied_q  <= selDenied_d;
            fault_q      <= fault_d;
            vendReq_q    <= (state_d == ST_VEND);
            busy_q       <= (state_d == ST_VEND) || (state_d == ST_PAYOUT);
        end
    end

    change_payout #(
        .CREDIT_W (CREDIT_W)
    ) u_payout (
        .clk            (clk),
        .rst_n          (rst_n),
        .load_i         (payLoad),
        .amount_i       (payAmount),
        .coinOutReady_i (coinOutReady),
        .coinOutValid_o (coinOutValid),
        .coinOutType_o  (coinOutType),
        .done_o         (payDone)
    );

    assign vendReq    = vendReq_q;
    assign vendSlot   = vendSlot_q;
    assign coinReject = coinReject_q;
    assign selDenied  = selDenied_q;
    assign fault      = fault_q;
    assign credit     = credit_q;
    assign busy       = busy_q;

endmodule
